// File: rtl/block_pkg.sv
// rtl/block_pkg.sv - shared types and constants for the falling-block spawn scheduler
package block_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    PICK   = 2'd2,
    LAUNCH = 2'd3
  } sched_state_t;

  localparam logic [15:0] LFSR_MASK = 16'hB400;
  localparam logic [3:0]  LEVEL_MAX = 4'd15;

  // Galois right-shift step; a non-zero state never maps to zero.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return (cur >> 1) ^ (cur[0] ? LFSR_MASK : 16'h0000);
  endfunction

endpackage

// File: rtl/lane_picker.sv
// rtl/lane_picker.sv - rotate-priority search for the first free lane from a start index
module lane_picker #(
  parameter int NUM_LANES = 5,
  parameter int IDX_W     = $clog2(NUM_LANES)
) (
  input  logic [IDX_W-1:0]     start,
  input  logic [NUM_LANES-1:0] lane_busy,
  output logic [IDX_W-1:0]     lane,
  output logic                 found
);

  int idx;

  // Scan from the far end back so the lane closest to start wins.
  always_comb begin
    lane  = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= NUM_LANES) idx = idx - NUM_LANES;
      if (!lane_busy[idx]) begin
        lane  = idx[IDX_W-1:0];
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/block_scheduler.sv
// rtl/block_scheduler.sv - decides when and in which lane the next falling block launches
module block_scheduler
  import block_pkg::*;
#(
  parameter int          NUM_LANES        = 5,
  parameter int          INTERVAL_W       = 8,
  parameter int          BASE_INTERVAL    = 60,
  parameter int          MIN_INTERVAL     = 15,
  parameter int          LEVEL_STEP       = 5,
  parameter int          SPAWNS_PER_LEVEL = 8,
  parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic                 Pause,
  input  logic                 frame_tick,
  input  logic [NUM_LANES-1:0] lane_busy,
  output logic [NUM_LANES-1:0] block_ready,
  output logic [3:0]           level,
  output logic [7:0]           spawn_count,
  output logic                 active
);

  localparam int IDX_W  = $clog2(NUM_LANES);
  localparam int CALC_W = INTERVAL_W + 4;

  sched_state_t          state;
  logic [15:0]           lfsr;
  logic [INTERVAL_W-1:0] frame_cnt;
  logic [7:0]            lvl_spawns;
  logic [7:0]            start_full;
  logic [IDX_W-1:0]      start;
  logic [IDX_W-1:0]      pick_lane;
  logic                  pick_found;
  logic [NUM_LANES-1:0]  lane_onehot;
  logic                  level_up;
  logic [3:0]            next_level;
  logic [INTERVAL_W-1:0] interval_next;
  logic [INTERVAL_W-1:0] interval_start;

  // Widened so level*step can never wrap before the floor comparison.
  function automatic logic [INTERVAL_W-1:0] interval_for(input logic [3:0] lvl);
    logic [CALC_W-1:0] cut;
    cut = CALC_W'(lvl) * CALC_W'(LEVEL_STEP);
    if (cut + CALC_W'(MIN_INTERVAL) >= CALC_W'(BASE_INTERVAL))
      return INTERVAL_W'(MIN_INTERVAL);
    return INTERVAL_W'(CALC_W'(BASE_INTERVAL) - cut);
  endfunction

  assign start_full = lfsr[7:0] % 8'(NUM_LANES);
  assign start      = start_full[IDX_W-1:0];

  lane_picker #(
    .NUM_LANES (NUM_LANES),
    .IDX_W     (IDX_W)
  ) u_lane_picker (
    .start     (start),
    .lane_busy (lane_busy),
    .lane      (pick_lane),
    .found     (pick_found)
  );

  assign lane_onehot    = {{(NUM_LANES-1){1'b0}}, 1'b1} << pick_lane;
  assign level_up       = (lvl_spawns == 8'(SPAWNS_PER_LEVEL - 1));
  assign next_level     = (level_up && level != LEVEL_MAX) ? level + 4'd1 : level;
  assign interval_next  = interval_for(next_level);
  assign interval_start = interval_for(4'd0);
  assign active         = (state != IDLE);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      block_ready <= '0;
      level       <= '0;
      spawn_count <= '0;
      lvl_spawns  <= '0;
      frame_cnt   <= '0;
      lfsr        <= LFSR_SEED;
    end else begin
      lfsr        <= lfsr_next(lfsr);
      block_ready <= '0;
      if (!Run) begin
        // Abort wins over everything; the game state is discarded.
        state       <= IDLE;
        level       <= '0;
        spawn_count <= '0;
        lvl_spawns  <= '0;
      end else begin
        case (state)
          IDLE: begin
            state       <= WAIT;
            frame_cnt   <= interval_start;
            level       <= '0;
            spawn_count <= '0;
            lvl_spawns  <= '0;
          end
          WAIT: begin
            if (frame_tick && !Pause) begin
              if (frame_cnt <= INTERVAL_W'(1)) begin
                frame_cnt <= '0;
                state     <= PICK;
              end else begin
                frame_cnt <= frame_cnt - INTERVAL_W'(1);
              end
            end
          end
          PICK: begin
            // The pulse is registered here so it is visible during LAUNCH.
            if (pick_found && !Pause) begin
              block_ready <= lane_onehot;
              spawn_count <= (spawn_count == 8'hFF) ? spawn_count : spawn_count + 8'd1;
              lvl_spawns  <= level_up ? 8'd0 : lvl_spawns + 8'd1;
              level       <= next_level;
              frame_cnt   <= interval_next;
              state       <= LAUNCH;
            end
          end
          LAUNCH: state <= WAIT;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_block_scheduler.sv
// tb/tb_block_scheduler.sv - directed bench with a frame-level spawn model for block_scheduler
module tb_block_scheduler;

  logic       Clk;
  logic       Reset;
  logic       Run;
  logic       Pause;
  logic       frame_tick;
  logic [4:0] lane_busy;
  logic [4:0] block_ready;
  logic [3:0] level;
  logic [7:0] spawn_count;
  logic       active;

  int checks;
  int errors;
  int pulses;
  bit checking;

  block_scheduler #(
    .NUM_LANES        (5),
    .INTERVAL_W       (8),
    .BASE_INTERVAL    (60),
    .MIN_INTERVAL     (15),
    .LEVEL_STEP       (5),
    .SPAWNS_PER_LEVEL (8),
    .LFSR_SEED        (16'hACE1)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Run         (Run),
    .Pause       (Pause),
    .frame_tick  (frame_tick),
    .lane_busy   (lane_busy),
    .block_ready (block_ready),
    .level       (level),
    .spawn_count (spawn_count),
    .active      (active)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a game that, while running, counts unpaused frame ticks down from
  // the level's interval, then waits for a free lane and fires one pulse.
  logic [15:0] m_lfsr;
  logic [15:0] m_cur;
  bit          m_active;
  bit          m_due;
  bit          m_found;
  int          m_left;
  int          m_level;
  int          m_count;
  int          m_lvl;
  int          m_start;
  int          m_idx;
  logic [4:0]  m_nxt;
  logic [4:0]  m_busy_used;
  logic [4:0]  exp_ready;
  logic [4:0]  prev_ready;

  function automatic int interval_of(input int lv);
    int v;
    v = 60 - lv * 5;
    return (v < 15) ? 15 : v;
  endfunction

  always @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      m_lfsr    = 16'hACE1;
      m_active  = 1'b0;
      m_due     = 1'b0;
      m_left    = 0;
      m_level   = 0;
      m_count   = 0;
      m_lvl     = 0;
      exp_ready = '0;
    end else begin
      m_cur  = m_lfsr;
      m_lfsr = {1'b0, m_cur[15:1]} ^ (m_cur[0] ? 16'hB400 : 16'h0000);
      m_nxt  = '0;
      if (!Run) begin
        m_active = 1'b0;
        m_due    = 1'b0;
        m_level  = 0;
        m_count  = 0;
        m_lvl    = 0;
      end else if (!m_active) begin
        m_active = 1'b1;
        m_due    = 1'b0;
        m_left   = interval_of(0);
        m_level  = 0;
        m_count  = 0;
        m_lvl    = 0;
      end else if (exp_ready != 0) begin
        // pulse cycle: the scheduler ignores ticks while launching
      end else if (m_due) begin
        if (!Pause) begin
          m_found = 1'b0;
          m_start = int'(m_cur[7:0]) % 5;
          for (int k = 0; k < 5; k++) begin
            if (!m_found) begin
              m_idx = (m_start + k) % 5;
              if (!lane_busy[m_idx]) begin
                m_found = 1'b1;
                m_nxt   = 5'b00001 << m_idx;
              end
            end
          end
          if (m_found) begin
            m_busy_used = lane_busy;
            m_count     = (m_count < 255) ? m_count + 1 : 255;
            m_lvl++;
            if (m_lvl == 8) begin
              m_lvl = 0;
              if (m_level < 15) m_level++;
            end
            m_left = interval_of(m_level);
            m_due  = 1'b0;
          end
        end
      end else if (frame_tick && !Pause) begin
        m_left--;
        if (m_left == 0) m_due = 1'b1;
      end
      exp_ready = m_nxt;
    end
  end

  always @(negedge Clk) begin
    if (checking) begin
      chk("block_ready", int'(block_ready), int'(exp_ready));
      chk("level", int'(level), m_level);
      chk("spawn_count", int'(spawn_count), m_count);
      chk("active", int'(active), int'(m_active));
      chk("onehot0", int'($onehot0(block_ready)), 1);
      chk("consecutive", int'(prev_ready != 0 && block_ready != 0), 0);
      chk("busy_lane", int'(|(block_ready & m_busy_used)), 0);
      if (block_ready != 0) pulses++;
      prev_ready = block_ready;
    end
  end

  task automatic tick();
    frame_tick = 1'b1;
    @(posedge Clk); #1;
    frame_tick = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
  endtask

  task automatic launches(input int n, input int iv);
    for (int i = 0; i < n; i++) repeat (iv) tick();
  endtask

  int p0;

  initial begin
    checks      = 0;
    errors      = 0;
    pulses      = 0;
    checking    = 1'b0;
    prev_ready  = '0;
    m_busy_used = '0;
    Reset       = 1'b1;
    Run         = 1'b0;
    Pause       = 1'b0;
    frame_tick  = 1'b0;
    lane_busy   = '0;
    repeat (2) @(posedge Clk);
    #1;
    checking = 1'b1;
    chk("rst_block_ready", int'(block_ready), 0);
    chk("rst_level", int'(level), 0);
    chk("rst_spawn_count", int'(spawn_count), 0);
    chk("rst_active", int'(active), 0);
    Reset = 1'b0;
    @(posedge Clk); #1;

    // First spawn after 60 ticks, two clocks after the last one
    Run = 1'b1;
    @(posedge Clk); #1;
    chk("run_active", int'(active), 1);
    repeat (59) tick();
    chk("no_pulse_59", pulses, 0);
    frame_tick = 1'b1;
    @(posedge Clk); #1;
    frame_tick = 1'b0;
    chk("pick_cycle_quiet", int'(block_ready), 0);
    @(posedge Clk); #1;
    chk("pulse_2clk", $countones(block_ready), 1);
    chk("spawn_count_1", int'(spawn_count), 1);
    @(posedge Clk); #1;
    chk("one_pulse", pulses, 1);

    // Level progression and interval floor
    launches(7, 60);
    chk("level_1", int'(level), 1);
    chk("spawn_8", int'(spawn_count), 8);
    repeat (54) tick();
    chk("lvl1_no_pulse_54", pulses, 8);
    tick();
    chk("lvl1_pulse_55", pulses, 9);
    launches(7, 55);
    for (int lv = 2; lv <= 8; lv++) launches(8, 60 - 5 * lv);
    chk("level_9", int'(level), 9);
    chk("spawn_72", int'(spawn_count), 72);
    repeat (14) tick();
    chk("lvl9_no_pulse_14", pulses, 72);
    tick();
    chk("lvl9_pulse_15", pulses, 73);
    launches(7, 15);
    chk("level_10", int'(level), 10);
    repeat (14) tick();
    chk("lvl10_no_pulse_14", pulses, 80);
    tick();
    chk("lvl10_pulse_15", pulses, 81);

    // All lanes busy holds the spawn until lane 2 frees up
    lane_busy = 5'b11111;
    repeat (15) tick();
    repeat (4) @(posedge Clk);
    #1;
    chk("all_busy_no_pulse", pulses, 81);
    chk("all_busy_active", int'(active), 1);
    lane_busy = 5'b11011;
    @(posedge Clk); #1;
    chk("lane2_pulse", int'(block_ready), 5'b00100);
    lane_busy = 5'b00000;
    repeat (2) @(posedge Clk);
    #1;

    // Abort clears the game; pause drops ticks
    Run = 1'b0;
    @(posedge Clk); #1;
    chk("abort_idle", int'(active), 0);
    chk("abort_level", int'(level), 0);
    Run = 1'b1;
    @(posedge Clk); #1;
    p0 = pulses;
    repeat (30) tick();
    Pause = 1'b1;
    repeat (20) tick();
    repeat (20) @(posedge Clk);
    #1;
    chk("pause_no_pulse", pulses, p0);
    Pause = 1'b0;
    repeat (29) tick();
    chk("pause_79_no_pulse", pulses, p0);
    tick();
    chk("pause_80_pulse", pulses, p0 + 1);

    // Run drop coinciding with the final tick
    launches(0, 60);
    repeat (59) tick();
    p0 = pulses;
    frame_tick = 1'b1;
    Run        = 1'b0;
    @(posedge Clk); #1;
    frame_tick = 1'b0;
    chk("abort_tick_idle", int'(active), 0);
    repeat (4) @(posedge Clk);
    #1;
    chk("abort_tick_no_pulse", pulses, p0);
    Run = 1'b1;
    @(posedge Clk); #1;
    chk("restart_active", int'(active), 1);
    chk("restart_level", int'(level), 0);
    chk("restart_count", int'(spawn_count), 0);

    // Asynchronous reset mid-countdown
    repeat (30) tick();
    Reset = 1'b1;
    #1;
    chk("async_rst_active", int'(active), 0);
    chk("async_rst_ready", int'(block_ready), 0);
    @(posedge Clk); #1;
    chk("rst_hold_count", int'(spawn_count), 0);
    Reset = 1'b0;
    @(posedge Clk); #1;
    p0 = pulses;
    repeat (60) tick();
    chk("post_rst_pulse", pulses, p0 + 1);
    chk("post_rst_count", int'(spawn_count), 1);

    checking = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
